expr_gen: RTL and testbench

EXPR_GEN -- requirements
Module: expr_gen

---
 rtl/expr_gen.sv | 125 ++++++++++++
 tb/tb_expr_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/expr_gen.sv
// Streams "d (op d)*" as ASCII characters over a valid/ready handshake.
// Define EXPR_GEN_EQ_EN to append a trailing '=' character to every expression.
module expr_gen (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [2:0]  nterms,
  input  logic [15:0] digits,
  input  logic [2:0]  ops,
  input  logic        out_ready,
  output logic [7:0]  out,
  output logic        out_valid,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

`ifdef EXPR_GEN_EQ_EN
  typedef enum logic [1:0] {IDLE, DIGIT, OP, EQ} state_t;
`else
  typedef enum logic [1:0] {IDLE, DIGIT, OP} state_t;
`endif

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic [2:0]  nt_q;
  logic [15:0] dig_q;
  logic [2:0]  ops_q;
  logic        err_q, err_n;
  logic        cap;
  logic        legal;
  logic        last_term;
  logic [3:0]  cur;

  // Only terms that will actually be emitted have to be decimal digits.
  always_comb begin
    legal = (nterms >= 3'd1) && (nterms <= 3'd4);
    for (int unsigned k = 0; k < 4; k++) begin
      if ((3'(k) < nterms) && (digits[4*k +: 4] > 4'd9))
        legal = 1'b0;
    end
  end

  assign last_term = ({1'b0, idx} == (nt_q - 3'd1));
  assign cur       = dig_q[{idx, 2'b00} +: 4];
  assign err       = err_q;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cap       = 1'b0;
    err_n     = 1'b0;
    out       = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (legal) begin
            cap     = 1'b1;
            idx_n   = '0;
            state_n = DIGIT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      DIGIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out       = 8'h30 + {4'h0, cur};
`ifdef EXPR_GEN_EQ_EN
        if (out_ready)
          state_n = last_term ? EQ : OP;
`else
        out_last = last_term;
        if (out_ready)
          state_n = last_term ? IDLE : OP;
`endif
      end
      OP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out       = ops_q[idx] ? 8'h2A : 8'h2B;
        if (out_ready) begin
          idx_n   = idx + 2'd1;
          state_n = DIGIT;
        end
      end
`ifdef EXPR_GEN_EQ_EN
      EQ: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out       = 8'h3D;
        out_last  = 1'b1;
        if (out_ready)
          state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      idx   <= '0;
      nt_q  <= '0;
      dig_q <= '0;
      ops_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      err_q <= err_n;
      if (cap) begin
        nt_q  <= nterms;
        dig_q <= digits;
        ops_q <= ops;
      end
    end
  end

endmodule

// File: tb/tb_expr_gen.sv
// Scoreboard bench for expr_gen: stimulus pushes expected characters, a monitor checks handshakes.
module tb_expr_gen;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  nterms = '0;
  logic [15:0] digits = '0;
  logic [2:0]  ops = '0;
  logic        out_ready = 1'b1;
  logic [7:0]  out;
  logic        out_valid, out_last, busy, err;

  int errors = 0;
  int checks = 0;
  logic [8:0] expq[$];

  always #5 clk = ~clk;

  expr_gen dut (
    .clk(clk), .clr(clr), .start(start), .nterms(nterms), .digits(digits),
    .ops(ops), .out_ready(out_ready), .out(out), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Expected character stream, {last, char}, derived from the request fields.
  task automatic push_expr(input int n, input logic [15:0] d, input logic [2:0] o);
    logic [3:0] t;
    bit eq;
`ifdef EXPR_GEN_EQ_EN
    eq = 1'b1;
`else
    eq = 1'b0;
`endif
    for (int k = 0; k < n; k++) begin
      t = d[4*k +: 4];
      expq.push_back({(k == n-1) && !eq, 8'h30 + {4'h0, t}});
      if (k < n-1) expq.push_back({1'b0, o[k] ? 8'h2A : 8'h2B});
    end
    if (eq) expq.push_back({1'b1, 8'h3D});
  endtask

  function automatic int expr_len(input int n);
`ifdef EXPR_GEN_EQ_EN
    return 2*n;
`else
    return 2*n - 1;
`endif
  endfunction

  always @(negedge clk) begin
    if (clr && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_char: got %0h last=%0b, required no character", out, out_last);
      end else begin
        check("char", {23'd0, out_last, out}, {23'd0, expq.pop_front()});
      end
    end
  end

  // Presents one request for one clock, then scrambles the inputs to prove they were captured.
  task automatic issue(input logic [2:0] n, input logic [15:0] d, input logic [2:0] o, input bit legal);
    @(negedge clk);
    start = 1'b1; nterms = n; digits = d; ops = o;
    if (legal) push_expr(int'(n), d, o);
    @(posedge clk); #1;
    start = 1'b0;
    nterms = 3'($urandom); digits = 16'($urandom); ops = 3'($urandom);
  endtask

  task automatic wait_done(input int exp_cycles, input string name);
    int cyc = 0;
    while (expq.size() != 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d characters outstanding, required 0", name, expq.size());
      expq.delete();
    end else if (exp_cycles >= 0) begin
      check({name, "_cycles"}, cyc, exp_cycles);
    end
    check({name, "_busy_after"}, {31'd0, busy}, 0);
    check({name, "_valid_after"}, {31'd0, out_valid}, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {24'd0, out}, 0);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_last", {31'd0, out_last}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_err", {31'd0, err}, 0);
    clr = 1'b1;

    // Basic "1+1*2"
    issue(3'd3, 16'h0211, 3'b010, 1'b1);
    check("basic_busy", {31'd0, busy}, 1);
    wait_done(expr_len(3), "basic");

    // Single term, unused upper nibbles illegal but ignored
    issue(3'd1, 16'hFFF9, 3'b111, 1'b1);
    wait_done(expr_len(1), "single");

    // Four terms, mixed operators: "6*7+8*9"
    issue(3'd4, 16'h9876, 3'b101, 1'b1);
    wait_done(expr_len(4), "four");

    // Illegal requests: digit out of range, nterms 0, nterms 5
    issue(3'd2, 16'h00A0, 3'b000, 1'b0);
    check("ill_digit_err", {31'd0, err}, 1);
    check("ill_digit_busy", {31'd0, busy}, 0);
    check("ill_digit_valid", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    check("ill_digit_err_pulse", {31'd0, err}, 0);
    issue(3'd0, 16'h0001, 3'b000, 1'b0);
    check("ill_n0_err", {31'd0, err}, 1);
    check("ill_n0_valid", {31'd0, out_valid}, 0);
    issue(3'd5, 16'h0000, 3'b000, 1'b0);
    check("ill_n5_err", {31'd0, err}, 1);
    @(posedge clk); #1;
    check("ill_n5_err_pulse", {31'd0, err}, 0);

    // Backpressure during '+', with a stray start pulse while busy
    issue(3'd3, 16'h0211, 3'b010, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_hold", {24'd0, out}, 32'h2B);
    start = 1'b1; nterms = 3'd1; digits = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("stall_hold", {24'd0, out}, 32'h2B);
      check("stall_valid", {31'd0, out_valid}, 1);
      check("stall_last", {31'd0, out_last}, 0);
    end
    out_ready = 1'b1;
    wait_done(expr_len(3) - 1, "stall");

    // Reset after the second character, then a fresh request
    issue(3'd3, 16'h0211, 3'b010, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    check("abort_out", {24'd0, out}, 0);
    check("abort_valid", {31'd0, out_valid}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_last", {31'd0, out_last}, 0);
    expq.delete();
    @(posedge clk); #1;
    clr = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_quiet", {31'd0, out_valid}, 0);
    end
    issue(3'd3, 16'h0211, 3'b010, 1'b1);
    wait_done(expr_len(3), "restart");

    // start held high: second expression after a one-cycle idle gap
    @(negedge clk);
    start = 1'b1; nterms = 3'd3; digits = 16'h0211; ops = 3'b010;
    push_expr(3, 16'h0211, 3'b010);
    push_expr(3, 16'h0211, 3'b010);
    @(posedge clk); #1;
    repeat (expr_len(3)) @(posedge clk);
    #1;
    check("held_gap_busy", {31'd0, busy}, 0);
    check("held_gap_valid", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("held_second_busy", {31'd0, busy}, 1);
    wait_done(expr_len(3), "held");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
